param_push_down_stack: RTL
==========================

Name: param_push_down_stack

Overview:
- Parametrised next-generation LIFO stack.
- Generalised in data width and depth; separate push/pop strobes; simultaneous push+pop (replace/bypass); synchronous flush; occupancy count; overflow/underflow error reporting.
- Drop-in storage for datapaths needing last-in-first-out buffering, such as expression evaluators and return-address stacks.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries (>=2; need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of count output. Derived localparam, not overridable.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous flush, active-high.
- push  in  1  push request.
- pop  in  1  pop request.
- data_i  in  WIDTH  data to push.
- data_o  out  WIDTH  registered popped data.
- valid_o  out  1  one-cycle pulse: data_o updated this cycle.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  CNT_W  current occupancy.
- ovf  out  1  overflow error.
- unf  out  1  underflow error.

Behaviour:
- Reset and clear:
  - All outputs register-based; all state updates on rising Clk.
  - Priority: Rst > clr > push/pop.
  - Rst=1: count=0, data_o=0, valid_o=0, ovf=0, unf=0, empty=1, full=0. Storage contents not cleared (don't-care).
  - Rst mid-operation: any push/pop in that cycle is discarded.
  - clr=1 (Rst=0): count=0, valid_o=0, ovf=0, unf=0. data_o holds. push/pop in that cycle ignored.
- Pointer and flags:
  - Stack pointer = count. Top entry = mem[count-1].
  - Pointer never wraps: saturates at 0 and DEPTH.
  - empty and full are decoded from the registered count, so they are valid in the same cycle as count.
- push=1, pop=0:
  - Not full: mem[count] <= data_i, count+1. valid_o=0.
  - Full: write ignored, count unchanged, ovf asserted.
- push=0, pop=1:
  - Not empty: data_o <= mem[count-1], count-1, valid_o=1 next cycle (latency 1).
  - Empty: data_o holds, valid_o=0, unf asserted.
- push=1, pop=1:
  - Not empty (including full): replace. data_o <= old top, mem[count-1] <= data_i, count unchanged, valid_o=1. No ovf.
  - Empty: bypass. data_o <= data_i, valid_o=1, count stays 0. No unf.
- Idle (push=0, pop=0): all state holds, valid_o=0.
- Error flags: default behaviour is single-cycle pulses in the cycle after the offending request. See Optional Feature for the alternative.
- Read-after-write: a value pushed in cycle N is poppable in cycle N+1 and appears on data_o in N+2.

Optional Feature:
- Macro: STACK_ERR_STICKY_EN.
- Defined: ovf and unf are sticky. Once set, they stay 1 until Rst or clr. Both can be set at once.
- Undefined: ovf and unf are one-cycle pulses per offending request. A continuous illegal request produces a continuous high flag.

Test Plan:
- Rst=1 for 2 cycles, then idle -> count=0, empty=1, full=0, data_o=0, valid_o=0, ovf=unf=0.
- Push 115 then 123, then pop twice (DEPTH=16) -> data_o=123 with valid_o=1, then 115 with valid_o=1; empty=1 afterwards; count sequence 1,2,1,0.
- DEPTH=4: push 1,2,3,4, then push 5 -> full=1, count=4, ovf pulses 1 cycle (sticky with STACK_ERR_STICKY_EN). Then pop -> data_o=4, not 5.
- Empty stack: pop -> unf=1, valid_o=0, data_o unchanged. Then push+pop with data_i=0x5A -> data_o=0x5A, valid_o=1, count=0.
- Stack holding 0x11,0x22: push+pop with data_i=0x33 -> data_o=0x22, count=2. Then pop -> 0x33, then pop -> 0x11.
- Stack holding 3 entries: assert clr together with push=1 -> count=0, empty=1, data_o holds its last value, flags cleared. Repeat with Rst and clr both high -> reset values.

Source files
------------

// File: rtl/param_push_down_stack.sv
// Parametrised LIFO stack: push/pop/replace/bypass, flush, occupancy and error flags.
// Define STACK_ERR_STICKY_EN to make ovf/unf sticky until Rst or clr.
module param_push_down_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_BYP,
    OP_OVF,
    OP_UNF
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  op_e              op;
  logic [CNT_W-1:0] top;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] dout_n;
  logic             vld_n;
  logic             ovf_n;
  logic             unf_n;
  logic             ovf_hit;
  logic             unf_hit;
  logic             we;
  logic [AW-1:0]    waddr;

  assign top = count - CNT_W'(1);

  // Classify the request against the registered empty/full flags.
  always_comb begin
    op = OP_IDLE;
    unique case (1'b1)
      push & ~pop & ~full:  op = OP_PUSH;
      push & ~pop & full:   op = OP_OVF;
      ~push & pop & ~empty: op = OP_POP;
      ~push & pop & empty:  op = OP_UNF;
      push & pop & ~empty:  op = OP_REPL;
      push & pop & empty:   op = OP_BYP;
      default:              op = OP_IDLE;
    endcase
  end

  // Next occupancy, output word and storage write for the decoded op.
  always_comb begin
    cnt_n   = count;
    dout_n  = data_o;
    vld_n   = 1'b0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    we      = 1'b0;
    waddr   = count[AW-1:0];
    unique case (op)
      OP_PUSH: begin
        we    = 1'b1;
        cnt_n = count + CNT_W'(1);
      end
      OP_POP: begin
        dout_n = mem[top[AW-1:0]];
        cnt_n  = top;
        vld_n  = 1'b1;
      end
      OP_REPL: begin
        dout_n = mem[top[AW-1:0]];
        we     = 1'b1;
        waddr  = top[AW-1:0];
        vld_n  = 1'b1;
      end
      OP_BYP: begin
        dout_n = data_i;
        vld_n  = 1'b1;
      end
      OP_OVF:  ovf_hit = 1'b1;
      OP_UNF:  unf_hit = 1'b1;
      default: ;
    endcase
`ifdef STACK_ERR_STICKY_EN
    ovf_n = ovf | ovf_hit;
    unf_n = unf | unf_hit;
`else
    ovf_n = ovf_hit;
    unf_n = unf_hit;
`endif
    if (clr | Rst) begin
      cnt_n  = '0;
      dout_n = data_o;
      vld_n  = 1'b0;
      ovf_n  = 1'b0;
      unf_n  = 1'b0;
      we     = 1'b0;
    end
  end

  // Control and output registers; Rst dominates clr and requests.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count   <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      count   <= cnt_n;
      data_o  <= dout_n;
      valid_o <= vld_n;
      ovf     <= ovf_n;
      unf     <= unf_n;
      empty   <= (cnt_n == '0);
      full    <= (cnt_n == CNT_W'(DEPTH));
    end
  end

  // Storage array, never reset; writes are suppressed by Rst and clr.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= data_i;
    end
  end

endmodule
